// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle divider co-unit.
package div_pkg;

  localparam int unsigned RegBus       = 32;
  localparam int unsigned DoubleRegBus = 2 * RegBus;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_if.sv
// EX <-> divider request/result bundle; EX is the master.
interface div_if #(
  parameter int unsigned WIDTH = div_pkg::RegBus
);
  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               start_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_abs.sv
// Conditional two's-complement negate; used for operand magnitudes and result sign fix-up.
module div_abs #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             neg_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);
  always_comb begin
    data_o = neg_i ? (~data_i + {{(WIDTH-1){1'b0}}, 1'b1}) : data_i;
  end
endmodule

// File: rtl/div.sv
// Radix-2 restoring divider, one quotient bit per clock, optional signed operation.
// Result is {remainder, quotient}; ready_o is held until EX drops start_i.
module div
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = RegBus,
  parameter int unsigned CNT_W = 6
) (
  input logic  clk,
  input logic  rst,
  div_if.slave bus
);

  div_state_e         state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] dividend_q;  // {partial remainder, dividend bits / quotient bits}
  logic [WIDTH-1:0]   divisor_q;
  logic               signed_q;
  logic               sign1_q;
  logic               sign2_q;

  logic [WIDTH-1:0]   mag1;
  logic [WIDTH-1:0]   mag2;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] dividend_step;

  div_abs #(.WIDTH(WIDTH)) u_abs_op1 (
    .neg_i  (bus.signed_div_i & bus.opdata1_i[WIDTH-1]),
    .data_i (bus.opdata1_i),
    .data_o (mag1)
  );

  div_abs #(.WIDTH(WIDTH)) u_abs_op2 (
    .neg_i  (bus.signed_div_i & bus.opdata2_i[WIDTH-1]),
    .data_i (bus.opdata2_i),
    .data_o (mag2)
  );

  div_abs #(.WIDTH(WIDTH)) u_fix_quo (
    .neg_i  (signed_q & (sign1_q ^ sign2_q)),
    .data_i (dividend_q[WIDTH-1:0]),
    .data_o (quo_fix)
  );

  // Remainder takes the sign of the dividend.
  div_abs #(.WIDTH(WIDTH)) u_fix_rem (
    .neg_i  (signed_q & sign1_q),
    .data_i (dividend_q[2*WIDTH-1:WIDTH]),
    .data_o (rem_fix)
  );

  // The partial remainder stays below the divisor, so WIDTH+1 bits never overflow.
  always_comb begin
    trial = {dividend_q[2*WIDTH-1:WIDTH], dividend_q[WIDTH-1]} - {1'b0, divisor_q};
    if (trial[WIDTH]) begin
      dividend_step = {dividend_q[2*WIDTH-2:0], 1'b0};
    end else begin
      dividend_step = {trial[WIDTH-1:0], dividend_q[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= DivFree;
      cnt_q        <= '0;
      dividend_q   <= '0;
      divisor_q    <= '0;
      signed_q     <= 1'b0;
      sign1_q      <= 1'b0;
      sign2_q      <= 1'b0;
      bus.result_o <= '0;
      bus.ready_o  <= DivResultNotReady;
    end else begin
      case (state_q)
        DivFree: begin
          bus.ready_o  <= DivResultNotReady;
          bus.result_o <= '0;
          if (bus.start_i == DivStart && !bus.annul_i) begin
            state_q    <= (bus.opdata2_i == '0) ? DivByZero : DivOn;
            cnt_q      <= '0;
            dividend_q <= {{WIDTH{1'b0}}, mag1};
            divisor_q  <= mag2;
            signed_q   <= bus.signed_div_i;
            sign1_q    <= bus.opdata1_i[WIDTH-1];
            sign2_q    <= bus.opdata2_i[WIDTH-1];
          end
        end
        DivByZero: begin
          state_q      <= DivEnd;
          dividend_q   <= '0;
          bus.result_o <= '0;
          bus.ready_o  <= DivResultReady;
        end
        DivOn: begin
          if (bus.annul_i) begin
            state_q <= DivFree;
          end else if (cnt_q == CNT_W'(WIDTH)) begin
            state_q      <= DivEnd;
            bus.result_o <= {rem_fix, quo_fix};
            bus.ready_o  <= DivResultReady;
          end else begin
            dividend_q <= dividend_step;
            cnt_q      <= cnt_q + 1'b1;
          end
        end
        DivEnd: begin
          if (bus.start_i == DivStop) begin
            state_q      <= DivFree;
            bus.result_o <= '0;
            bus.ready_o  <= DivResultNotReady;
          end
        end
        default: state_q <= DivFree;
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// Directed-vector bench for the multi-cycle divider.
module tb_div;
  import div_pkg::*;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  div_if #(.WIDTH(W)) bus ();

  div #(.WIDTH(W), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " ready"}, 64'(bus.ready_o), 64'd0);
    check({tag, " result"}, bus.result_o, 64'd0);
    check({tag, " state"}, 64'(dut.state_q), 64'(DivFree));
  endtask

  // Issue one divide from idle; operands are scrambled after acceptance to prove they are latched.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
    int n = 0;
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    do begin
      tick();
      n++;
      if (n == 1) begin
        bus.opdata1_i    = ~a;
        bus.opdata2_i    = b ^ 32'h0000_0005;
        bus.signed_div_i = ~sgn;
      end
    end while (!bus.ready_o && n < 60);
    check({tag, " latency"}, 64'(n), 64'(exp_lat));
    check({tag, " result"}, bus.result_o, exp);
    tick();
    check({tag, " hold ready"}, 64'(bus.ready_o), 64'd1);
    check({tag, " hold result"}, bus.result_o, exp);
    check({tag, " hold state"}, 64'(dut.state_q), 64'(DivEnd));
    bus.start_i = 1'b0;
    tick();
    check_idle({tag, " release"});
  endtask

  initial begin
    int seen;
    rst              = 1'b1;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    repeat (2) tick();
    check_idle("reset");
    check("reset cnt", 64'(dut.cnt_q), 64'd0);
    check("reset dividend", dut.dividend_q, 64'd0);
    check("reset divisor", 64'(dut.divisor_q), 64'd0);
    rst = 1'b0;
    tick();

    run_div("u100/7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 34);
    run_div("s-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34);
    run_div("u-7/2", 1'b0, 32'hFFFF_FFF9, 32'd2, {32'h0000_0001, 32'h7FFF_FFFC}, 34);
    run_div("s7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 34);
    run_div("div0", 1'b1, 32'd1234, 32'd0, 64'd0, 2);
    run_div("smin/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 34);
    run_div("umax/1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 34);
    run_div("u5/9", 1'b0, 32'd5, 32'd9, {32'd5, 32'd0}, 34);

    // start together with annul is not accepted
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd9;
    bus.opdata2_i    = 32'd3;
    bus.start_i      = 1'b1;
    bus.annul_i      = 1'b1;
    tick();
    check("start+annul state", 64'(dut.state_q), 64'(DivFree));
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    tick();

    // Flush during iteration 10
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    bus.start_i   = 1'b1;
    repeat (10) tick();
    check("annul pre state", 64'(dut.state_q), 64'(DivOn));
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    tick();
    bus.annul_i = 1'b0;
    check_idle("annul");
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.ready_o) seen++;
    end
    check("annul ready never", 64'(seen), 64'd0);
    run_div("after annul 9/3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 34);

    // Reset mid-iteration
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    bus.start_i   = 1'b1;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    check_idle("rst in DivOn");
    rst         = 1'b0;
    bus.start_i = 1'b0;
    tick();

    // Reset in DivEnd with start still high
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    bus.start_i   = 1'b1;
    repeat (34) tick();
    check("rst DivEnd pre ready", 64'(bus.ready_o), 64'd1);
    rst = 1'b1;
    tick();
    check_idle("rst in DivEnd");
    rst         = 1'b0;
    bus.start_i = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div.md
Name: div

Overview:
- Multi-cycle 32-bit integer divider; sits beside the EX stage as its long-latency co-unit.
- EX issues dividend/divisor plus a start request and holds the pipeline stalled until the divider reports ready.
- EX then writes the 64-bit result into HI/LO via its hi_o/lo_o/we_o path.
- Radix-2 restoring algorithm, one quotient bit per clock, with optional signed operation.

Parameters:
- WIDTH, 32, operand width; the result is 2*WIDTH.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- signed_div_i  in  1  1 = signed divide, 0 = unsigned
- opdata1_i  in  WIDTH  dividend
- opdata2_i  in  WIDTH  divisor
- start_i  in  1  request; EX holds it high until it has consumed ready_o
- annul_i  in  1  cancel the in-flight divide (pipeline flush)
- result_o  out  2*WIDTH  {remainder, quotient}
- ready_o  out  1  result_o valid

Behaviour:
- All state and outputs are registered.
- Reset values: state=DIV_FREE, cnt=0, dividend register=0, divisor register=0, result_o=0, ready_o=0.
- Reset takes priority in any state, including mid-divide.
- State DIV_FREE (idle):
  - ready_o=0, result_o=0.
  - If start_i=1 and annul_i=0 at an edge:
    - divisor==0 -> DIV_BYZERO.
    - Otherwise -> DIV_ON, cnt=0.
  - On that same edge, latch the operands.
    - Signed mode: latch |opdata1_i| and |opdata2_i| as two's-complement magnitudes; 0x80000000 maps to magnitude 0x80000000.
    - Latch the original sign bits of both operands.
- State DIV_BYZERO: next edge -> DIV_END with internal result=0.
- State DIV_ON:
  - If annul_i=1: -> DIV_FREE; nothing is written to result_o; ready_o stays 0.
  - Otherwise, each edge:
    - Form the trial value {partial remainder, next dividend bit} minus the divisor, at WIDTH+1 bits.
    - If non-negative: keep the difference and shift in a quotient bit of 1.
    - Otherwise: keep the old value and shift in 0.
    - cnt increments.
  - When cnt reaches WIDTH: -> DIV_END.
- State DIV_END:
  - On the entry edge:
    - ready_o=1.
    - result_o = {remainder, quotient}, sign-corrected when signed_div_i=1.
    - Quotient is negated iff sign1^sign2.
    - Remainder is negated iff sign1; its sign follows the dividend.
  - Hold both outputs while start_i=1.
  - When start_i=0 at an edge: -> DIV_FREE, ready_o=0, result_o=0.
- Latency, counted from the accepting edge:
  - Normal divide: ready_o rises on edge 34 (1 accept + 32 iterations + 1 finish).
  - Divide by zero: ready_o rises on edge 2.
- Boundary cases:
  - signed_div_i, opdata1_i and opdata2_i are sampled only at acceptance; later input changes are ignored.
  - start_i with annul_i at the same edge in DIV_FREE: not accepted.
  - Signed 0x80000000 / 0xFFFFFFFF: quotient wraps to 0x80000000, remainder 0; no trap.
  - annul_i in DIV_BYZERO or DIV_END: ignored; exit from DIV_END only on start_i=0.
  - A new start_i is not accepted until the block has returned to DIV_FREE, so there is at least one idle cycle between divides.

Decomposition:
- Shared defines header holds:
  - State codes DivFree=2'b00, DivByZero=2'b01, DivOn=2'b10, DivEnd=2'b11.
  - DivStart / DivStop, DivResultReady / DivResultNotReady.
  - DoubleRegBus and RegBus widths.
- No sub-module required.
- If reuse is wanted, the magnitude/negate helper may be split out as div_abs (combinational).

Test Plan:
- Unsigned 100/7, start held high -> ready_o at edge 34; result_o = {0x00000002, 0x0000000E}.
- Signed -7/2 (0xFFFFFFF9, 0x00000002) -> result_o = {0xFFFFFFFF, 0xFFFFFFFD}; unsigned on the same operands -> quotient 0x7FFFFFFC, remainder 0x00000001.
- Divide by zero (any/0) -> ready_o at edge 2, result_o = 0.
- Signed 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}.
- annul_i pulsed in iteration 10 -> state returns to DIV_FREE, ready_o never rises; a following 9/3 gives {0, 3}.
- rst asserted mid-DIV_ON, and separately in DIV_END with start_i still high -> next edge result_o=0, ready_o=0, state=DIV_FREE.
- start_i dropped one cycle after ready_o -> ready_o and result_o clear on the next edge; a back-to-back start is accepted only from DIV_FREE.
